// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the step controller: button FSM state encoding and
// a small helper used to size the internal counters.
package step_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DEB_DN = 3'd1;
    localparam logic [2:0] ST_FIRE   = 3'd2;
    localparam logic [2:0] ST_HELD   = 3'd3;
    localparam logic [2:0] ST_DEB_UP = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        DEB_DN = ST_DEB_DN,
        FIRE   = ST_FIRE,
        HELD   = ST_HELD,
        DEB_UP = ST_DEB_UP
    } btn_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/step_ctrl_if.sv
// Operator-facing signals of the step controller: raw button/switch in,
// clean step enable, step count and status levels out.
interface step_ctrl_if #(
    parameter int CNT_W = 16
);

    logic             buttom;
    logic             run_sw;
    logic             step_en;
    logic [CNT_W-1:0] step_cnt;
    logic             btn_db;
    logic             run_mode;

    modport master (
        input  buttom,
        input  run_sw,
        output step_en,
        output step_cnt,
        output btn_db,
        output run_mode
    );

    modport slave (
        output buttom,
        output run_sw,
        input  step_en,
        input  step_cnt,
        input  btn_db,
        input  run_mode
    );

endinterface

// File: rtl/step_ctrl_sync_debounce.sv
// Two-flop synchronizer followed by a stability filter: the level output only
// follows the synchronized input after DEB_CYCLES consecutive differing samples.
module step_ctrl_sync_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic synced,
    output logic level
);

    localparam int DW = $clog2(DEB_CYCLES);

    logic          meta;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            synced <= 1'b0;
        end else begin
            meta   <= din;
            synced <= meta;
        end
    end

    // Any sample that agrees with the current level restarts the stability run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (synced == level) begin
            cnt <= '0;
        end else if (cnt == DW'(DEB_CYCLES - 1)) begin
            level <= synced;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// Turns a bouncy step button and a run/step switch into a single-cycle datapath
// clock enable, and counts the steps issued since reset.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 500000,
    parameter int RUN_DIV    = 25,
    parameter int CNT_W      = 16
) (
    input logic        clk,
    input logic        rst,
    step_ctrl_if.master bus
);

    localparam int CW = $clog2(max_int(DEB_CYCLES, RUN_DIV));

    logic             rst_meta;
    logic             rst_n;
    logic             btn_sync;
    logic             btn_level_unused;
    logic             run_sync_unused;
    logic             run_mode;
    btn_state_t       state;
    btn_state_t       state_nxt;
    logic [CW-1:0]    deb_cnt;
    logic [CW-1:0]    deb_cnt_nxt;
    logic [CW-1:0]    div_cnt;
    logic             run_tick;
    logic             step_en;
    logic [CNT_W-1:0] step_cnt;

    // Reset asserts immediately but is released only after two clean clock edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    step_ctrl_sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (bus.run_sw),
        .synced (run_sync_unused),
        .level  (run_mode)
    );

    // The button only needs the synchronizer; its debounce lives in the FSM below.
    step_ctrl_sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (bus.buttom),
        .synced (btn_sync),
        .level  (btn_level_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            deb_cnt <= '0;
        end else begin
            state   <= state_nxt;
            deb_cnt <= deb_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        deb_cnt_nxt = deb_cnt;
        if (run_mode) begin
            state_nxt   = IDLE;
            deb_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state_nxt   = DEB_DN;
                        deb_cnt_nxt = '0;
                    end
                end
                DEB_DN: begin
                    if (!btn_sync) begin
                        state_nxt   = IDLE;
                        deb_cnt_nxt = '0;
                    end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
                        state_nxt   = FIRE;
                        deb_cnt_nxt = '0;
                    end else begin
                        deb_cnt_nxt = deb_cnt + 1'b1;
                    end
                end
                FIRE: begin
                    state_nxt = HELD;
                end
                HELD: begin
                    if (!btn_sync) begin
                        state_nxt   = DEB_UP;
                        deb_cnt_nxt = '0;
                    end
                end
                DEB_UP: begin
                    if (btn_sync) begin
                        state_nxt   = HELD;
                        deb_cnt_nxt = '0;
                    end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
                        state_nxt   = IDLE;
                        deb_cnt_nxt = '0;
                    end else begin
                        deb_cnt_nxt = deb_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt   = IDLE;
                    deb_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Divider is held at zero outside run mode so each run period starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!run_mode || run_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign run_tick = run_mode && (div_cnt == CW'(RUN_DIV - 1));
    assign step_en  = (state == FIRE) || run_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
        end else if (step_en) begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    assign bus.step_en  = step_en;
    assign bus.step_cnt = step_cnt;
    assign bus.btn_db   = (state == FIRE) || (state == HELD) || (state == DEB_UP);
    assign bus.run_mode = run_mode;

endmodule

// File: tb/tb_step_ctrl.sv
// Self-checking bench for step_ctrl: directed scenarios plus random bouncy
// inputs, compared each cycle against a streak-counting behavioural model.
module tb_step_ctrl;

    localparam int DEB     = 4;
    localparam int RDIV    = 5;
    localparam int CW_T    = 4;
    localparam int CNT_MOD = 1 << CW_T;
    localparam int MAXC    = 4096;

    logic clk = 1'b0;
    logic rst;

    always #2 clk = ~clk;

    step_ctrl_if #(.CNT_W(CW_T)) bus ();

    step_ctrl #(
        .DEB_CYCLES (DEB),
        .RUN_DIV    (RDIV),
        .CNT_W      (CW_T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int phase_pulses = 0;

    bit in_b   [MAXC];
    bit in_r   [MAXC];
    bit rst_hi [MAXC];
    bit rsti   [MAXC];

    bit m_btn, m_run, m_fire;
    int m_bstreak, m_rstreak, m_age, m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic bit rst_low(input int idx);
        return (idx < 0) ? 1'b1 : !rst_hi[idx];
    endfunction

    function automatic bit was_reset(input int idx);
        return (idx < 0) ? 1'b1 : rsti[idx];
    endfunction

    function automatic bit model_step();
        return m_fire || (m_run && (m_age % RDIV == 0));
    endfunction

    task automatic model_reset();
        m_btn = 0; m_run = 0; m_fire = 0;
        m_bstreak = 0; m_rstreak = 0; m_age = 0; m_cnt = 0;
    endtask

    // Inputs reach the logic two cycles late, or as 0 while the chain was held in reset.
    task automatic model_advance();
        bit sb, sr, n_run, n_btn, n_fire;
        sb = (!was_reset(cyc - 1) && !was_reset(cyc - 2)) ? in_b[cyc - 2] : 1'b0;
        sr = (!was_reset(cyc - 1) && !was_reset(cyc - 2)) ? in_r[cyc - 2] : 1'b0;
        m_cnt = (m_cnt + (model_step() ? 1 : 0)) % CNT_MOD;
        n_run = m_run;
        if (sr != m_run) begin
            m_rstreak++;
            if (m_rstreak == DEB) begin
                n_run = sr;
                m_rstreak = 0;
            end
        end else begin
            m_rstreak = 0;
        end
        n_btn = m_btn;
        n_fire = 0;
        if (m_run) begin
            n_btn = 0;
            m_bstreak = 0;
        end else if (!m_fire) begin
            if (sb != m_btn) begin
                m_bstreak++;
                if (m_bstreak == DEB + 1) begin
                    n_btn = sb;
                    n_fire = sb;
                    m_bstreak = 0;
                end
            end else begin
                m_bstreak = 0;
            end
        end
        m_age  = n_run ? (m_run ? m_age + 1 : 1) : 0;
        m_run  = n_run;
        m_btn  = n_btn;
        m_fire = n_fire;
    endtask

    task automatic checkOutput();
        if (bus.step_en === 1'b1) phase_pulses++;
        check("step_en",  32'(bus.step_en),  32'(model_step()));
        check("step_cnt", 32'(bus.step_cnt), 32'(m_cnt));
        check("btn_db",   32'(bus.btn_db),   32'(m_btn));
        check("run_mode", 32'(bus.run_mode), 32'(m_run));
    endtask

    task automatic applyStimulus(input bit b, input bit r, input bit rs);
        if (cyc >= MAXC) begin
            $display("[TB] FAIL cycle_budget: observed %0d expected below %0d", cyc, MAXC);
            $fatal(1, "[TB] cycle budget exhausted");
        end
        @(posedge clk);
        #1;
        rst = rs;
        bus.buttom = b;
        bus.run_sw = r;
        in_b[cyc] = b;
        in_r[cyc] = r;
        rst_hi[cyc] = rs;
        rsti[cyc] = rst_low(cyc) || rst_low(cyc - 1) || rst_low(cyc - 2);
        if (rsti[cyc]) model_reset();
        @(negedge clk);
        checkOutput();
        if (!rsti[cyc]) model_advance();
        cyc++;
    endtask

    task automatic repeat_stim(input int n, input bit b, input bit r, input bit rs);
        for (int i = 0; i < n; i++) applyStimulus(b, r, rs);
    endtask

    initial begin
        bit b, r, rs;
        int len;
        rst = 1'b0;
        bus.buttom = 1'b0;
        bus.run_sw = 1'b0;
        model_reset();

        $display("[TB] reset with button held");
        repeat_stim(3, 1'b1, 1'b0, 1'b0);
        repeat_stim(10, 1'b0, 1'b0, 1'b1);
        check("reset_cnt", 32'(bus.step_cnt), 32'd0);
        check("reset_btn_db", 32'(bus.btn_db), 32'd0);

        $display("[TB] clean press");
        phase_pulses = 0;
        repeat_stim(20, 1'b1, 1'b0, 1'b1);
        repeat_stim(12, 1'b0, 1'b0, 1'b1);
        check("press_pulses", 32'(phase_pulses), 32'd1);
        check("press_cnt", 32'(bus.step_cnt), 32'd1);
        check("press_release_db", 32'(bus.btn_db), 32'd0);

        $display("[TB] bounce then hold");
        phase_pulses = 0;
        for (int i = 0; i < 6; i++) applyStimulus(bit'(i % 2 == 0), 1'b0, 1'b1);
        check("bounce_no_early", 32'(phase_pulses), 32'd0);
        repeat_stim(10, 1'b1, 1'b0, 1'b1);
        repeat_stim(12, 1'b0, 1'b0, 1'b1);
        check("bounce_pulses", 32'(phase_pulses), 32'd1);

        $display("[TB] short glitch");
        phase_pulses = 0;
        repeat_stim(2, 1'b1, 1'b0, 1'b1);
        repeat_stim(10, 1'b0, 1'b0, 1'b1);
        check("glitch_pulses", 32'(phase_pulses), 32'd0);
        check("glitch_cnt", 32'(bus.step_cnt), 32'd2);

        $display("[TB] run mode with button presses");
        phase_pulses = 0;
        repeat_stim(10, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 50; i++) applyStimulus(bit'($urandom_range(0, 1)), 1'b1, 1'b1);
        repeat_stim(20, 1'b0, 1'b1, 1'b1);
        repeat_stim(20, 1'b0, 1'b0, 1'b1);
        check("run_pulses", 32'(phase_pulses), 32'd16);
        check("run_cnt_wrap", 32'(bus.step_cnt), 32'd2);

        $display("[TB] run switched off mid-divide");
        phase_pulses = 0;
        repeat_stim(17, 1'b0, 1'b1, 1'b1);
        repeat_stim(20, 1'b0, 1'b0, 1'b1);
        check("partial_run_pulses", 32'(phase_pulses), 32'd3);
        check("partial_run_cnt", 32'(bus.step_cnt), 32'd5);

        $display("[TB] reset while held");
        repeat_stim(12, 1'b1, 1'b0, 1'b1);
        check("held_db", 32'(bus.btn_db), 32'd1);
        repeat_stim(3, 1'b1, 1'b0, 1'b0);
        check("held_reset_cnt", 32'(bus.step_cnt), 32'd0);
        check("held_reset_db", 32'(bus.btn_db), 32'd0);
        phase_pulses = 0;
        repeat_stim(15, 1'b1, 1'b0, 1'b1);
        check("repress_pulses", 32'(phase_pulses), 32'd1);
        check("repress_cnt", 32'(bus.step_cnt), 32'd1);
        repeat_stim(12, 1'b0, 1'b0, 1'b1);

        $display("[TB] random bouncy stimulus");
        r = 1'b0;
        for (int seg = 0; seg < 150; seg++) begin
            len = $urandom_range(1, 12);
            b = bit'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) r = ~r;
            rs = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < len; i++) applyStimulus(b, r, (i < 2) ? rs : 1'b1);
        end
        repeat_stim(20, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
